// File: rtl/systolic_result_drain.sv
// Snapshots the 2x2 systolic result after a fixed settle latency and streams it out in raster order.
// Optional build macro SYSTOLIC_DRAIN_RELU_EN clamps negative elements to zero at capture.
module systolic_result_drain #(
  parameter int DATA_W  = 8,
  parameter int LATENCY = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] o00,
  input  logic [DATA_W-1:0] o01,
  input  logic [DATA_W-1:0] o10,
  input  logic [DATA_W-1:0] o11,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {
    S_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [DATA_W-1:0] snap_q [4];
  logic [DATA_W-1:0] snap_d [4];
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  function automatic logic [DATA_W-1:0] clamp_elem(input logic [DATA_W-1:0] v);
`ifdef SYSTOLIC_DRAIN_RELU_EN
    clamp_elem = v[DATA_W-1] ? '0 : v;
`else
    clamp_elem = v;
`endif
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    busy_d    = busy_q;
    done_d    = done_q;

    unique case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          snap_d[0] = clamp_elem(o00);
          snap_d[1] = clamp_elem(o01);
          snap_d[2] = clamp_elem(o10);
          snap_d[3] = clamp_elem(o11);
          idx_d     = 2'd0;
          m_data_d  = clamp_elem(o00);
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          state_d   = S_SEND;
        end
      end

      S_SEND: begin
        // Outputs only advance on an accepted beat, so a stall holds data and last as-is.
        if (m_ready) begin
          if (idx_q == 2'd3) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            m_data_d  = '0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end else begin
            idx_d    = idx_q + 2'd1;
            m_data_d = snap_q[idx_q + 2'd1];
            m_last_d = (idx_q == 2'd2);
          end
        end
      end

      S_DONE: begin
        m_valid_d = 1'b0;
        m_data_d  = '0;
        busy_d    = 1'b0;
        done_d    = 1'b1;
      end

      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_WAIT;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      for (int i = 0; i < 4; i++) snap_q[i] <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Bench for systolic_result_drain: table of result sets streamed under several ready patterns.
module tb_systolic_result_drain;

  localparam int LAT = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] o00, o01, o10, o11;
  logic [7:0] m_data;
  logic       m_valid, m_ready, m_last, busy, done;

  int checks = 0;
  int passed = 0;

  systolic_result_drain #(.DATA_W(8), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .o00(o00), .o01(o01), .o10(o10), .o11(o11),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][7:0] o;
    logic [3:0][7:0] e;
    int              mode;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic logic [3:0][7:0] mk(input logic [7:0] a, b, c, d);
    logic [3:0][7:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  // Reference element transform: negative two's-complement values become zero under ReLU.
  function automatic logic [7:0] ref_elem(input logic [7:0] v);
`ifdef SYSTOLIC_DRAIN_RELU_EN
    int s;
    s = $signed(v);
    return (s < 0) ? 8'd0 : v;
`else
    return v;
`endif
  endfunction

  task automatic run_case(input logic [3:0][7:0] o, input logic [3:0][7:0] e,
                          input int mode, input int abort_after);
    int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    int n, ecnt, pi;
    logic bad, r;
    rst = 1'b1; m_ready = 1'b0;
    o00 = o[0]; o01 = o[1]; o10 = o[2]; o11 = o[3];
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      m_ready = 1'($urandom_range(0, 1));
      if (m_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || m_data !== 8'd0) bad = 1'b1;
    end
    check("wait_idle", 32'(bad), 0);
    @(negedge clk);
    check("valid_rise", 32'(m_valid), 1);
    check("busy_send", 32'(busy), 1);
    o00 = 8'hAA; o01 = 8'hAA; o10 = 8'hAA; o11 = 8'hAA;
    n = 0; ecnt = LAT; pi = 0;
    for (int it = 0; it < 200 && n < 4; it++) begin
      if (mode == 0) r = 1'b1;
      else if (mode == 1) r = (pi < 7) ? 1'(pat[pi]) : 1'b1;
      else r = 1'($urandom_range(0, 1));
      pi++;
      m_ready = r;
      check($sformatf("valid_b%0d", n), 32'(m_valid), 1);
      check($sformatf("data_b%0d", n), 32'(m_data), 32'(e[n]));
      check($sformatf("last_b%0d", n), 32'(m_last), 32'(n == 3));
      if (r) n++;
      if (abort_after > 0 && n == abort_after) begin
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_valid", 32'(m_valid), 0);
        check("abort_data", 32'(m_data), 0);
        check("abort_busy", 32'(busy), 1);
        check("abort_done", 32'(done), 0);
        return;
      end
      @(negedge clk);
      ecnt++;
    end
    check("beat_count", 32'(n), 4);
    check("done_set", 32'(done), 1);
    check("busy_clr", 32'(busy), 0);
    check("valid_clr", 32'(m_valid), 0);
    check("data_clr", 32'(m_data), 0);
    check("last_clr", 32'(m_last), 0);
    if (mode == 0) check("done_edge", 32'(ecnt), 32'(LAT + 4));
    bad = 1'b0;
    repeat (4) begin
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done !== 1'b1 || m_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    check("done_hold", 32'(bad), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0][7:0] rv;
    rst = 1'b1; m_ready = 1'b1;
    o00 = 8'd1; o01 = 8'd2; o10 = 8'd3; o11 = 8'd4;
    #1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      check("rst_valid", 32'(m_valid), 0);
      check("rst_last", 32'(m_last), 0);
      check("rst_data", 32'(m_data), 0);
      check("rst_busy", 32'(busy), 1);
      check("rst_done", 32'(done), 0);
    end

    tbl[0].o = mk(8'd67, 8'd74, 8'd34, 8'd59);
    tbl[0].e = mk(8'd67, 8'd74, 8'd34, 8'd59);
    tbl[0].mode = 0;
    tbl[1] = tbl[0];
    tbl[1].mode = 1;
    tbl[2].o = mk(8'hF0, 8'h7F, 8'h80, 8'h01);
`ifdef SYSTOLIC_DRAIN_RELU_EN
    tbl[2].e = mk(8'd0, 8'd127, 8'd0, 8'd1);
`else
    tbl[2].e = mk(8'd240, 8'd127, 8'd128, 8'd1);
`endif
    tbl[2].mode = 0;
    for (int t = 3; t < 6; t++) begin
      for (int j = 0; j < 4; j++) begin
        rv[j] = 8'($urandom);
        tbl[t].e[j] = ref_elem(rv[j]);
      end
      tbl[t].o = rv;
      tbl[t].mode = 2;
    end

    for (int t = 0; t < 6; t++) run_case(tbl[t].o, tbl[t].e, tbl[t].mode, 0);

    // Reset after the second beat, then a fresh run must start again from o00.
    run_case(tbl[3].o, tbl[3].e, 0, 2);
    run_case(tbl[0].o, tbl[0].e, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
